// File: rtl/e213_pkg.sv
// Shared constants and trellis helpers for the (2,1,3) hard-decision Viterbi frame sequencer.
// Encoder state bit 0 holds the newest input bit.
package e213_pkg;
    localparam int NS = 8;
    localparam logic [3:0] GEN_C0 = 4'b1111;
    localparam logic [3:0] GEN_C1 = 4'b1101;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SEARCH = 2'd1,
        REPORT = 2'd2
    } fsm_state_t;

    function automatic logic [2:0] pred_a(input logic [2:0] n);
        return {1'b0, n[2:1]};
    endfunction

    function automatic logic [2:0] pred_b(input logic [2:0] n);
        return {1'b1, n[2:1]};
    endfunction

    // Encoder output {c0,c1} on the branch leaving predecessor p with input u.
    function automatic logic [1:0] code_bits(input logic [2:0] p, input logic u);
        logic [3:0] r;
        r = {u, p[0], p[1], p[2]};
        return {^(r & GEN_C0), ^(r & GEN_C1)};
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] x);
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction
endpackage

// File: rtl/e213_bmu.sv
// Branch metric unit: Hamming distance of the received pair to both branches entering each state.
module e213_bmu
    import e213_pkg::*;
(
    input  logic [1:0]      sym_data,
    output logic [2*NS-1:0] hd_ina,
    output logic [2*NS-1:0] hd_inb
);
    for (genvar gi = 0; gi < NS; gi++) begin : g_branch
        localparam logic [2:0] N = 3'(gi);
        assign hd_ina[2*gi +: 2] = popcount2(sym_data ^ code_bits(pred_a(N), N[0]));
        assign hd_inb[2*gi +: 2] = popcount2(sym_data ^ code_bits(pred_b(N), N[0]));
    end
endmodule

// File: rtl/e213_acs_ctrl.sv
// Frame sequencer: path-metric bank, ACS port fan-out, survivor writes and end-of-frame
// minimum-metric search handed to traceback over valid/ready.
module e213_acs_ctrl
    import e213_pkg::*;
#(
    parameter int W         = 8,
    parameter int FRAME_LEN = 64,
    parameter int INIT_PM   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sym_valid,
    input  logic [1:0]            sym_data,
    output logic                  sym_ready,
    output logic [NS*W-1:0]       acs_ppm_ina,
    output logic [NS*W-1:0]       acs_ppm_inb,
    output logic [2*NS-1:0]       hd_ina,
    output logic [2*NS-1:0]       hd_inb,
    input  logic [NS*W-1:0]       acs_ppm_out,
    input  logic [NS-1:0]         acs_bx_out,
    output logic                  surv_we,
    output logic [$clog2(FRAME_LEN)-1:0] surv_addr,
    output logic [NS-1:0]         surv_data,
    output logic                  best_valid,
    output logic [2:0]            best_state,
    output logic [W-1:0]          best_metric,
    input  logic                  tb_ready
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [1:0] ST_RUN    = 2'(RUN);
    localparam logic [1:0] ST_SEARCH = 2'(SEARCH);
    localparam logic [1:0] ST_REPORT = 2'(REPORT);

    logic [1:0]    state_reg;
    logic [AW-1:0] stage_cnt_reg;
    logic [2:0]    scan_idx_reg;
    logic [W-1:0]  pm_reg [NS];
    logic [W-1:0]  pm_new [NS];
    logic [NS-1:0] msb_vec;
    logic          all_msb;
    logic          accept;

    e213_bmu u_bmu (
        .sym_data (sym_data),
        .hd_ina   (hd_ina),
        .hd_inb   (hd_inb)
    );

    assign sym_ready = (state_reg == ST_RUN);
    assign accept    = sym_valid && sym_ready;
    assign all_msb   = &msb_vec;

    for (genvar gi = 0; gi < NS; gi++) begin : g_state
        localparam logic [2:0] N = 3'(gi);
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        logic [W-1:0] po;

        assign pa = pm_reg[pred_a(N)];
        assign pb = pm_reg[pred_b(N)];
        assign po = acs_ppm_out[gi*W +: W];
        assign acs_ppm_ina[gi*W +: W] = pa;
        assign acs_ppm_inb[gi*W +: W] = pb;
        assign msb_vec[gi] = po[W-1];
        // Subtracting 2^(W-1) from every state preserves all metric differences.
        assign pm_new[gi] = {po[W-1] & ~all_msb, po[W-2:0]};

        // A new metric never drops below both predecessors unless the adder wrapped.
        always_ff @(posedge clk) begin
            if (!rst && accept) begin
                assert (po >= ((pa < pb) ? pa : pb))
                    else $error("acs metric wrapped in state %0d", gi);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            stage_cnt_reg <= '0;
            scan_idx_reg  <= '0;
            for (int i = 0; i < NS; i++) pm_reg[i] <= (i == 0) ? '0 : W'(INIT_PM);
            surv_we       <= 1'b0;
            surv_addr     <= '0;
            surv_data     <= '0;
            best_valid    <= 1'b0;
            best_state    <= '0;
            best_metric   <= '0;
        end else begin
            surv_we <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (sym_valid) begin
                        for (int i = 0; i < NS; i++) pm_reg[i] <= pm_new[i];
                        surv_we   <= 1'b1;
                        surv_addr <= stage_cnt_reg;
                        surv_data <= acs_bx_out;
                        if (stage_cnt_reg == AW'(FRAME_LEN - 1)) begin
                            state_reg    <= ST_SEARCH;
                            scan_idx_reg <= '0;
                        end else begin
                            stage_cnt_reg <= stage_cnt_reg + AW'(1);
                        end
                    end
                end
                ST_SEARCH: begin
                    // Strict less-than keeps the lowest index on ties.
                    if (scan_idx_reg == 3'd0 || pm_reg[scan_idx_reg] < best_metric) begin
                        best_metric <= pm_reg[scan_idx_reg];
                        best_state  <= scan_idx_reg;
                    end
                    if (scan_idx_reg == 3'(NS - 1)) begin
                        state_reg  <= ST_REPORT;
                        best_valid <= 1'b1;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + 3'd1;
                    end
                end
                ST_REPORT: begin
                    if (tb_ready) begin
                        best_valid    <= 1'b0;
                        state_reg     <= ST_RUN;
                        stage_cnt_reg <= '0;
                        for (int i = 0; i < NS; i++) pm_reg[i] <= (i == 0) ? '0 : W'(INIT_PM);
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_e213_acs_ctrl.sv
// Directed bench for e213_acs_ctrl: two instances (W=8/FRAME_LEN=8 and W=5/FRAME_LEN=256)
// each driven by a behavioural ACS unit and checked against an independent trellis model.
module tb_e213_acs_ctrl;
    typedef int pm_t [8];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: W=8, FRAME_LEN=8, INIT_PM=32
    logic        a_valid, a_ready, a_we, a_bv, a_tbr;
    logic [1:0]  a_data;
    logic [63:0] a_ina, a_inb, a_out;
    logic [15:0] a_hda, a_hdb;
    logic [7:0]  a_bx, a_sd, a_bm;
    logic [2:0]  a_addr, a_bs;
    logic [7:0]  a_ta, a_tb;

    // Instance B: W=5, FRAME_LEN=256, INIT_PM=8
    logic        b_valid, b_ready, b_we, b_bv;
    logic        b_tbr = 1'b0;
    logic [1:0]  b_data;
    logic [39:0] b_ina, b_inb, b_out;
    logic [15:0] b_hda, b_hdb;
    logic [7:0]  b_bx, b_sd, b_addr;
    logic [2:0]  b_bs;
    logic [4:0]  b_bm, b_ta, b_tb;

    pm_t ma, mb, gb;

    e213_acs_ctrl #(.W(8), .FRAME_LEN(8), .INIT_PM(32)) dut_a (
        .clk(clk), .rst(rst), .sym_valid(a_valid), .sym_data(a_data), .sym_ready(a_ready),
        .acs_ppm_ina(a_ina), .acs_ppm_inb(a_inb), .hd_ina(a_hda), .hd_inb(a_hdb),
        .acs_ppm_out(a_out), .acs_bx_out(a_bx), .surv_we(a_we), .surv_addr(a_addr),
        .surv_data(a_sd), .best_valid(a_bv), .best_state(a_bs), .best_metric(a_bm),
        .tb_ready(a_tbr)
    );

    e213_acs_ctrl #(.W(5), .FRAME_LEN(256), .INIT_PM(8)) dut_b (
        .clk(clk), .rst(rst), .sym_valid(b_valid), .sym_data(b_data), .sym_ready(b_ready),
        .acs_ppm_ina(b_ina), .acs_ppm_inb(b_inb), .hd_ina(b_hda), .hd_inb(b_hdb),
        .acs_ppm_out(b_out), .acs_bx_out(b_bx), .surv_we(b_we), .surv_addr(b_addr),
        .surv_data(b_sd), .best_valid(b_bv), .best_state(b_bs), .best_metric(b_bm),
        .tb_ready(b_tbr)
    );

    // Behavioural ACS units: add-compare-select, ties go to the ina path.
    always_comb begin
        a_out = '0; a_bx = '0; a_ta = '0; a_tb = '0;
        for (int n = 0; n < 8; n++) begin
            a_ta = a_ina[n*8 +: 8] + {6'd0, a_hda[2*n +: 2]};
            a_tb = a_inb[n*8 +: 8] + {6'd0, a_hdb[2*n +: 2]};
            a_bx[n] = (a_tb < a_ta);
            a_out[n*8 +: 8] = (a_tb < a_ta) ? a_tb : a_ta;
        end
    end

    always_comb begin
        b_out = '0; b_bx = '0; b_ta = '0; b_tb = '0;
        for (int n = 0; n < 8; n++) begin
            b_ta = b_ina[n*5 +: 5] + {3'd0, b_hda[2*n +: 2]};
            b_tb = b_inb[n*5 +: 5] + {3'd0, b_hdb[2*n +: 2]};
            b_bx[n] = (b_tb < b_ta);
            b_out[n*5 +: 5] = (b_tb < b_ta) ? b_tb : b_ta;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift-register encoder: c0 = u^s0^s1^s2, c1 = u^s0^s2 (s0 newest).
    function automatic logic [1:0] enc(input int p, input int u);
        logic s0, s1, s2, uu;
        s0 = p[0]; s1 = p[1]; s2 = p[2]; uu = u[0];
        return {uu ^ s0 ^ s1 ^ s2, uu ^ s0 ^ s2};
    endfunction

    function automatic int hd(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] d;
        d = x ^ y;
        return int'(d[0]) + int'(d[1]);
    endfunction

    task automatic mstep(input pm_t pin, input logic [1:0] s, input int half,
                         output pm_t pout, output logic [7:0] bx);
        int ca, cb, a;
        bit all_hi;
        all_hi = 1'b1;
        bx = '0;
        for (int n = 0; n < 8; n++) begin
            a  = n >> 1;
            ca = pin[a] + hd(s, enc(a, n & 1));
            cb = pin[a + 4] + hd(s, enc(a + 4, n & 1));
            bx[n]   = (cb < ca);
            pout[n] = (cb < ca) ? cb : ca;
            if (pout[n] < half) all_hi = 1'b0;
        end
        if (half > 0 && all_hi)
            for (int n = 0; n < 8; n++) pout[n] = pout[n] - half;
    endtask

    task automatic init_pm(output pm_t p, input int init);
        p[0] = 0;
        for (int n = 1; n < 8; n++) p[n] = init;
    endtask

    task automatic read_a(output pm_t p);
        for (int k = 0; k < 4; k++) begin
            p[k]     = int'(a_ina[2*k*8 +: 8]);
            p[k + 4] = int'(a_inb[2*k*8 +: 8]);
        end
    endtask

    task automatic read_b(output pm_t p);
        for (int k = 0; k < 4; k++) begin
            p[k]     = int'(b_ina[2*k*5 +: 5]);
            p[k + 4] = int'(b_inb[2*k*5 +: 5]);
        end
    endtask

    task automatic check_pm_a(input string tag);
        pm_t obs;
        read_a(obs);
        for (int n = 0; n < 8; n++) chk($sformatf("%s_pm%0d", tag, n), obs[n], ma[n]);
    endtask

    task automatic send_a(input logic [1:0] s, input int k);
        pm_t np;
        logic [7:0] bx;
        mstep(ma, s, 128, np, bx);
        chk("a_ready_before_accept", a_ready, 1);
        a_valid = 1'b1; a_data = s;
        @(posedge clk); #1;
        a_valid = 1'b0;
        ma = np;
        chk($sformatf("a_we_stage%0d", k), a_we, 1);
        chk($sformatf("a_addr_stage%0d", k), a_addr, k);
        chk($sformatf("a_dec_stage%0d", k), a_sd, bx);
        check_pm_a($sformatf("a_stage%0d", k));
    endtask

    task automatic send_b(input logic [1:0] s, input int k);
        pm_t np, ng, obs;
        logic [7:0] bx, bxg;
        mstep(mb, s, 16, np, bx);
        mstep(gb, s, 0, ng, bxg);
        b_valid = 1'b1; b_data = s;
        @(posedge clk); #1;
        b_valid = 1'b0;
        mb = np; gb = ng;
        chk($sformatf("b_we_stage%0d", k), b_we, 1);
        chk($sformatf("b_addr_stage%0d", k), b_addr, k);
        chk($sformatf("b_dec_stage%0d", k), b_sd, bxg);
        read_b(obs);
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("b_pm%0d_stage%0d", n, k), obs[n], mb[n]);
            chk($sformatf("b_diff%0d_stage%0d", n, k), obs[n] - obs[0], gb[n] - gb[0]);
        end
    endtask

    // Called in the cycle after the terminal accept; best_valid must rise exactly 9 cycles after it.
    task automatic end_frame_a(input int exp_state, input int exp_metric);
        int mmin, midx;
        chk("a_ready_search", a_ready, 0);
        chk("a_bv_search_c1", a_bv, 0);
        for (int c = 2; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c < 9) begin
                chk($sformatf("a_bv_search_c%0d", c), a_bv, 0);
                chk($sformatf("a_we_search_c%0d", c), a_we, 0);
            end
        end
        chk("a_bv_rise", a_bv, 1);
        mmin = ma[0]; midx = 0;
        for (int n = 1; n < 8; n++) if (ma[n] < mmin) begin mmin = ma[n]; midx = n; end
        chk("a_best_state", a_bs, exp_state);
        chk("a_best_metric", a_bm, exp_metric);
        chk("a_best_state_model", a_bs, midx);
        chk("a_best_metric_model", a_bm, mmin);
    endtask

    task automatic handshake_a();
        a_tbr = 1'b1;
        @(posedge clk); #1;
        a_tbr = 1'b0;
        init_pm(ma, 32);
        chk("a_bv_after_hs", a_bv, 0);
        chk("a_ready_after_hs", a_ready, 1);
        check_pm_a("a_reinit");
    endtask

    initial begin
        logic [1:0] t3 [8];
        logic [1:0] s;
        rst = 1'b1;
        a_valid = 1'b0; a_data = 2'b00; a_tbr = 1'b0;
        b_valid = 1'b0; b_data = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        init_pm(ma, 32);
        init_pm(mb, 8);
        init_pm(gb, 8);

        // Reset values and idle
        for (int c = 0; c < 5; c++) begin
            chk("rst_ready", a_ready, 1);
            chk("rst_we", a_we, 0);
            chk("rst_bv", a_bv, 0);
            @(posedge clk); #1;
        end
        chk("rst_addr", a_addr, 0);
        chk("rst_sd", a_sd, 0);
        chk("rst_bs", a_bs, 0);
        chk("rst_bm", a_bm, 0);
        chk("rst_ina0", a_ina[7:0], 0);
        chk("rst_ina1", a_ina[15:8], 0);
        chk("rst_inb0", a_inb[7:0], 32);
        chk("rst_inb1", a_inb[15:8], 32);

        // All-zero frame, back-to-back
        for (int k = 0; k < 8; k++) send_a(2'b00, k);
        end_frame_a(0, 0);
        handshake_a();

        // Encoded 1,0,1,1,0 + tail -> 11,11,01,11,01,01,11,00; symbol 2 flipped to 00
        t3 = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00};
        for (int k = 0; k < 8; k++) send_a(t3[k], k);
        end_frame_a(0, 1);

        // Traceback stall with a symbol on offer
        a_valid = 1'b1; a_data = 2'b10;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("stall_bv", a_bv, 1);
            chk("stall_bs", a_bs, 0);
            chk("stall_bm", a_bm, 1);
            chk("stall_ready", a_ready, 0);
            chk("stall_we", a_we, 0);
        end
        a_valid = 1'b0;
        handshake_a();

        // Long random frame on the narrow instance, with periodic idle cycles
        for (int k = 0; k < 200; k++) begin
            s = 2'($urandom_range(0, 3));
            send_b(s, k);
            if (k % 37 == 36) begin
                @(posedge clk); #1;
                chk("b_idle_we", b_we, 0);
                chk("b_idle_pm0", b_ina[4:0], mb[0]);
            end
        end

        // Partial frame, idle cycle, then reset coincident with the stage-5 accept
        send_a(2'b10, 0);
        send_a(2'b01, 1);
        send_a(2'b11, 2);
        @(posedge clk); #1;
        chk("a_idle_we", a_we, 0);
        check_pm_a("a_idle");
        send_a(2'b00, 3);
        send_a(2'b10, 4);
        a_valid = 1'b1; a_data = 2'b01; rst = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; rst = 1'b0;
        init_pm(ma, 32);
        chk("midrst_we", a_we, 0);
        chk("midrst_addr", a_addr, 0);
        chk("midrst_ready", a_ready, 1);
        check_pm_a("midrst");
        send_a(2'b01, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
